// File: rtl/alu_shift_pkg.sv
// Shared definitions for the sequential ALU shift units (left and right variants).
package alu_shift_pkg;

    // Shift amount width: a 32-bit datapath needs shift distances 0..31
    localparam int SHAMT_W = 5;

    // Bit positions of the shift amount in the instruction word (sll/srl)
    // and in the register operand (sllv/srlv)
    localparam int SHAMT_HI  = 10;
    localparam int SHAMT_LO  = 6;
    localparam int SHAMTV_HI = 4;
    localparam int SHAMTV_LO = 0;

    // Control states common to every sequential shifter
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } shift_state_t;

endpackage

// File: rtl/shl_step.sv
// One step of the sequential left shifter: a combinational shift by a small amount.
module shl_step
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   value,
    input  logic [SHAMT_W-1:0] amt,
    output logic [WIDTH-1:0]   result
);

    // Zero-filled logical left shift; bits leaving the MSB are dropped
    assign result = value << amt;

endmodule

// File: rtl/sll32_seq.sv
// Multi-cycle logical left shifter (sll/sllv) with a start/busy/done handshake.
module sll32_seq
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             var_sel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] res,
    output logic             busy,
    output logic             done
);

    // Reject unsupported configurations at elaboration time
    if (WIDTH != 32) begin : g_bad_width
        $error("sll32_seq: only WIDTH=32 is supported");
    end
    if (STEP != 1 && STEP != 2 && STEP != 4 && STEP != 8) begin : g_bad_step
        $error("sll32_seq: STEP must be 1, 2, 4 or 8");
    end

    localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

    shift_state_t       state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [SHAMT_W-1:0] step_amt;
    logic [SHAMT_W-1:0] shamt_sel;
    logic [WIDTH-1:0]   acc_shifted;

    // Only B[10:6] and B[4:0] carry a shift amount; the rest of B is ignored
    logic unused_b;
    assign unused_b = ^{B[WIDTH-1:SHAMT_HI+1], B[SHAMT_LO-1:SHAMTV_HI+1]};

    // Per-cycle shift distance: a full step, or whatever remains if less
    assign step_amt = (cnt_q < STEP_AMT) ? cnt_q : STEP_AMT;

    // Pick the shift amount field: immediate field for sll, register field for sllv
    assign shamt_sel = var_sel ? B[SHAMTV_HI:SHAMTV_LO] : B[SHAMT_HI:SHAMT_LO];

    shl_step #(
        .WIDTH (WIDTH)
    ) u_shl_step (
        .value  (acc_q),
        .amt    (step_amt),
        .result (acc_shifted)
    );

    // Next-state logic: capture on start in IDLE, shift down the count, pulse done once
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d  = A;
                    cnt_d  = shamt_sel;
                    busy_d = 1'b1;
                    if (shamt_sel == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                acc_d  = acc_shifted;
                cnt_d  = cnt_q - step_amt;
                busy_d = 1'b1;
                if (cnt_d == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any shift in progress and clears the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign res  = acc_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_sll32_seq.sv
// Self-checking bench for sll32_seq: one STEP=1 instance and one STEP=4 instance.
module tb_sll32_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        start4;
    logic        var_sel;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] res;
    logic        busy;
    logic        done;
    logic [31:0] res4;
    logic        busy4;
    logic        done4;

    int checks;
    int failures;
    logic [31:0] exp_q[$];

    sll32_seq #(.WIDTH(32), .STEP(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .var_sel (var_sel),
        .A       (A),
        .B       (B),
        .res     (res),
        .busy    (busy),
        .done    (done)
    );

    sll32_seq #(.WIDTH(32), .STEP(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .start   (start4),
        .var_sel (var_sel),
        .A       (A),
        .B       (B),
        .res     (res4),
        .busy    (busy4),
        .done    (done4)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference shift amount selection
    function automatic int ref_shamt(input logic [31:0] b, input logic vs);
        return vs ? int'(b[4:0]) : int'(b[10:6]);
    endfunction

    // Reference start-to-done latency in cycles
    function automatic int ref_lat(input int sh, input int step);
        return (sh + step - 1) / step + 1;
    endfunction

    // Issue one request and wait (bounded) for done; reports result, latency and busy behaviour
    task automatic do_op(input bit use4, input logic [31:0] a, input logic [31:0] b,
                         input logic vs, output logic [31:0] r, output int lat,
                         output bit busy_ok, output bit timed_out);
        @(negedge clk);
        A = a;
        B = b;
        var_sel = vs;
        if (use4) start4 = 1'b1;
        else      start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start4 = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        timed_out = 1'b1;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (!(use4 ? busy4 : busy)) busy_ok = 1'b0;
            if (use4 ? done4 : done) begin
                timed_out = 1'b0;
                r = use4 ? res4 : res;
                break;
            end
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({res, busy, done} !== {32'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_state: got res=%h busy=%b done=%b expected res=0 busy=0 done=0", res, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] r;
        int lat;
        bit bok, tmo, saw_done;
        @(negedge clk);
        A = 32'h0000_0001;
        B = 32'h0000_0500;
        var_sel = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({res, busy, done} !== {32'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_abort: got res=%h busy=%b done=%b expected res=0 busy=0 done=0", res, busy, done);
        end
        saw_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_no_done: got done pulse=%b expected 0", saw_done);
        end
        exp_q.push_back(32'h0000_0002);
        do_op(1'b0, 32'h0000_0001, 32'h0000_0040, 1'b0, r, lat, bok, tmo);
        checks++;
        if (tmo || r !== exp_q.pop_front()) begin
            failures++;
            $display("[TB] FAIL reset_recover: got res=%h timeout=%b expected 00000002", r, tmo);
        end
    endtask

    task automatic test_basic();
        logic [31:0] r;
        int lat;
        bit bok, tmo;
        exp_q.push_back(32'h0000_0010);
        do_op(1'b0, 32'h0000_0001, 32'h0000_0100, 1'b0, r, lat, bok, tmo);
        checks++;
        if (tmo || r !== exp_q.pop_front()) begin
            failures++;
            $display("[TB] FAIL basic_res: got %h timeout=%b expected 00000010", r, tmo);
        end
        checks++;
        if (lat !== 5) begin
            failures++;
            $display("[TB] FAIL basic_latency: got %0d expected 5", lat);
        end
        checks++;
        if (bok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_busy: busy dropped before done, expected high cycles 1..5");
        end
        @(negedge clk);
        checks++;
        if ({done, busy, res} !== {1'b0, 1'b0, 32'h0000_0010}) begin
            failures++;
            $display("[TB] FAIL basic_after_done: got done=%b busy=%b res=%h expected 0 0 00000010", done, busy, res);
        end
    endtask

    task automatic test_zero_and_max();
        logic [31:0] r;
        int lat;
        bit bok, tmo;
        exp_q.push_back(32'hDEAD_BEEF);
        do_op(1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, r, lat, bok, tmo);
        checks++;
        if (tmo || r !== exp_q.pop_front() || lat !== 1) begin
            failures++;
            $display("[TB] FAIL zero_shift: got res=%h lat=%0d expected DEADBEEF lat=1", r, lat);
        end
        exp_q.push_back(32'h8000_0000);
        do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_07C0, 1'b0, r, lat, bok, tmo);
        checks++;
        if (tmo || r !== exp_q.pop_front() || lat !== 32) begin
            failures++;
            $display("[TB] FAIL max_shift: got res=%h lat=%0d expected 80000000 lat=32", r, lat);
        end
    endtask

    task automatic test_sllv();
        logic [31:0] r;
        int lat;
        bit bok, tmo;
        exp_q.push_back(32'h3456_7800);
        do_op(1'b0, 32'h1234_5678, 32'h0000_07C8, 1'b1, r, lat, bok, tmo);
        checks++;
        if (tmo || r !== exp_q.pop_front() || lat !== 9) begin
            failures++;
            $display("[TB] FAIL sllv_select: got res=%h lat=%0d expected 34567800 lat=9", r, lat);
        end
    endtask

    task automatic test_step4();
        logic [31:0] r;
        int lat;
        bit bok, tmo;
        exp_q.push_back(32'h0000_0C00);
        do_op(1'b1, 32'h0000_0003, 32'h0000_0280, 1'b0, r, lat, bok, tmo);
        checks++;
        if (tmo || r !== exp_q.pop_front() || lat !== 4) begin
            failures++;
            $display("[TB] FAIL step4_shift: got res=%h lat=%0d expected 00000C00 lat=4", r, lat);
        end
        exp_q.push_back(32'h8000_0000);
        do_op(1'b1, 32'hFFFF_FFFF, 32'h0000_001F, 1'b1, r, lat, bok, tmo);
        checks++;
        if (tmo || r !== exp_q.pop_front() || lat !== 9) begin
            failures++;
            $display("[TB] FAIL step4_max: got res=%h lat=%0d expected 80000000 lat=9", r, lat);
        end
    endtask

    // start held high with A/B changing every cycle: each IDLE cycle accepts one request
    task automatic test_back_to_back();
        int cnt_m;
        int sh;
        int results;
        int pushed;
        int wait_cycles;
        logic [31:0] e;
        cnt_m = 0;
        results = 0;
        pushed = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (done) begin
                e = exp_q.pop_front();
                results++;
                checks++;
                if (res !== e) begin
                    failures++;
                    $display("[TB] FAIL b2b_res: got %h expected %h", res, e);
                end
            end
            A = $urandom;
            B = $urandom & 32'h0000_07FF & ~32'h0000_0400;
            var_sel = 1'($urandom_range(0, 1));
            start = 1'b1;
            if (cnt_m == 0) begin
                sh = ref_shamt(B, var_sel);
                exp_q.push_back(A << sh);
                pushed++;
                cnt_m = ref_lat(sh, 1);
            end else begin
                cnt_m--;
            end
        end
        @(negedge clk);
        start = 1'b0;
        if (done) begin
            e = exp_q.pop_front();
            results++;
            checks++;
            if (res !== e) begin
                failures++;
                $display("[TB] FAIL b2b_res: got %h expected %h", res, e);
            end
        end
        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 64) begin
            @(negedge clk);
            wait_cycles++;
            if (done) begin
                e = exp_q.pop_front();
                results++;
                checks++;
                if (res !== e) begin
                    failures++;
                    $display("[TB] FAIL b2b_res: got %h expected %h", res, e);
                end
            end
        end
        repeat (40) begin
            @(negedge clk);
            if (done) results++;
        end
        checks++;
        if (results !== pushed) begin
            failures++;
            $display("[TB] FAIL b2b_count: got %0d results expected %0d", results, pushed);
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        logic vs;
        int lat;
        int sh;
        int bad;
        bit bok, tmo, use4;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            vs = 1'($urandom_range(0, 1));
            use4 = (i % 4 == 3);
            sh = ref_shamt(b, vs);
            exp_q.push_back(a << sh);
            do_op(use4, a, b, vs, r, lat, bok, tmo);
            e = exp_q.pop_front();
            checks++;
            if (tmo || r !== e || lat !== ref_lat(sh, use4 ? 4 : 1)) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("[TB] FAIL random_op: A=%h shamt=%0d step4=%b got res=%h lat=%0d expected res=%h lat=%0d",
                             a, sh, use4, r, lat, e, ref_lat(sh, use4 ? 4 : 1));
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        start = 1'b0;
        start4 = 1'b0;
        var_sel = 1'b0;
        A = '0;
        B = '0;
        rst = 1'b1;
        test_reset();
        test_reset_mid_shift();
        test_basic();
        test_zero_and_max();
        test_sllv();
        test_step4();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
